// File: rtl/hamming_uart_tx.sv
// hamming_uart_tx: Hamming(7,4) encoder feeding an 8N1-style UART transmitter.
// A nibble accepted on a data_valid/data_ready handshake is encoded, optionally
// corrupted in one bit (inject_err) and shifted out LSB first:
//   start(0), code[0..6], [even parity], stop(1), CLKS_PER_BIT cycles per bit.
// Build option: define HAMMING_UART_TX_PARITY_EN to insert the parity bit
// (10-bit frame); without it the frame is 9 bits.
module hamming_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  input  logic [2:0] inject_err,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [6:0] code_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef HAMMING_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [9:0] BAUD_LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST  = 3'd6;

  logic [2:0] state_q, state_d;
  logic [9:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic [6:0] code_q, code_d;

  logic       baud_done;
  logic       handshake;
  logic [6:0] enc;
  logic [6:0] err_mask;

  // Hamming(7,4) encoder and single-bit error-injection mask
  always_comb begin
    enc[0] = data_in[0] ^ data_in[1] ^ data_in[3];
    enc[1] = data_in[0] ^ data_in[2] ^ data_in[3];
    enc[2] = data_in[0];
    enc[3] = data_in[1] ^ data_in[2] ^ data_in[3];
    enc[4] = data_in[1];
    enc[5] = data_in[2];
    enc[6] = data_in[3];
    err_mask = '0;
    if (inject_err != 3'd0) begin
      err_mask[inject_err - 3'd1] = 1'b1;
    end
  end

  // Handshake and status outputs derived from registered state
  always_comb begin
    data_ready = (state_q == S_IDLE) && ena && !rst;
    handshake  = data_valid && data_ready;
    baud_done  = (baud_q == BAUD_LAST);
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_STOP) && baud_done;
    code_out   = code_q;
  end

  // Next-state logic: one baud period per bit, bit index walks 0..6 in DATA
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d = S_START;
          baud_d  = '0;
          idx_d   = '0;
          code_d  = enc ^ err_mask;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          idx_d   = '0;
        end else begin
          baud_d = baud_q + 10'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef HAMMING_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 10'd1;
        end
      end
`ifdef HAMMING_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 10'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 10'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Serial line: decoded from state so it follows the state register directly
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = code_q[idx_q];
`ifdef HAMMING_UART_TX_PARITY_EN
      S_PARITY: tx = ^code_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  // State registers with synchronous reset; reset truncates any frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
    end
  end

endmodule
